// File: rtl/branch_address_stack.sv
// LIFO of branch-target addresses with push/pop/replace-top, occupancy decode and
// sticky overflow/underflow flags. Q is the top entry and is released when cs=1.
module branch_address_stack #(
    parameter int NrOfBits = 8,
    parameter int Depth    = 4,
    parameter int CntBits  = 3
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ClockEnable,
    input  logic                Tick,
    input  logic                Push,
    input  logic                Pop,
    input  logic                Clear,
    input  logic [NrOfBits-1:0] D,
    input  logic                cs,
    output logic [NrOfBits-1:0] Q,
    output logic [CntBits-1:0]  Count,
    output logic                Empty,
    output logic                Full,
    output logic                Overflow,
    output logic                Underflow
);

    localparam int IdxBits = $clog2(Depth);

    logic [NrOfBits-1:0] mem_q [Depth];
    logic [CntBits-1:0]  count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                wr_en;
    logic [IdxBits-1:0]  wr_idx;
    logic                en;
    logic                empty, full;
    logic [IdxBits-1:0]  top_idx;
    logic [NrOfBits-1:0] top;

    assign en      = ClockEnable & Tick;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CntBits'(Depth));
    assign top_idx = IdxBits'(count_q - 1'b1);

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_idx  = IdxBits'(count_q);
        if (en) begin
            if (Clear) begin
                count_d = '0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
            end else if (Push && Pop) begin
                // Replace-top keeps Count; on an empty stack it degrades to a plain push.
                wr_en = 1'b1;
                if (!empty) begin
                    wr_idx = top_idx;
                end else begin
                    wr_idx  = '0;
                    count_d = CntBits'(1);
                end
            end else if (Push) begin
                if (!full) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (Pop) begin
                if (!empty) begin
                    count_d = count_q - 1'b1;
                end else begin
                    unf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (wr_en) begin
                mem_q[wr_idx] <= D;
            end
        end
    end

    assign top       = empty ? '0 : mem_q[top_idx];
    assign Q         = cs ? 'z : top;
    assign Count     = count_q;
    assign Empty     = empty;
    assign Full      = full;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

endmodule
